// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - lane-mode codes, sequencer state encoding and dummy pattern shared by the QSPI blocks
package qspi_pkg;

  typedef enum logic [1:0] {
    LANE_STD  = 2'b00,
    LANE_DUAL = 2'b01,
    LANE_QUAD = 2'b10
  } lane_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4
  } state_e;

  localparam logic [7:0] DUMMY_BYTE = 8'hFF;

  // The reserved lane code falls back to single-lane so the byte engine never sees it.
  function automatic logic [1:0] lane_fix(input logic [1:0] t);
    return (t == 2'b11) ? 2'(LANE_STD) : t;
  endfunction

endpackage

// File: rtl/qspi_cmd_seq.sv
// rtl/qspi_cmd_seq.sv - QSPI command/address/dummy/data byte sequencer feeding the SPI byte engine
// Define QSPI_SEQ_ADDR4B_EN for per-request 4-byte addressing (adds the req_addr4b input).
module qspi_cmd_seq
  import qspi_pkg::*;
#(
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [7:0]       req_cmd,
  input  logic [31:0]      req_addr,
  input  logic             req_addr_en,
  input  logic [3:0]       req_dummy,
  input  logic [LEN_W-1:0] req_len,
  input  logic [1:0]       req_cmd_type,
  input  logic [1:0]       req_addr_type,
  input  logic [1:0]       req_dat_type,
`ifdef QSPI_SEQ_ADDR4B_EN
  input  logic             req_addr4b,
`endif
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [7:0]       wr_dat,
  output logic             o_spi_vld,
  input  logic             i_spi_rdy,
  output logic [7:0]       o_spi_dat,
  output logic [1:0]       o_spi_type,
  output logic             o_spi_continue,
  output logic             busy,
  output logic             done
);

  logic req_is_4b;

`ifdef QSPI_SEQ_ADDR4B_EN
  localparam int ADDR_W = 32;
  assign req_is_4b = req_addr4b | (|req_addr[31:24]);
`else
  localparam int ADDR_W = 24;
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:24];
  assign req_is_4b      = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               addr_en_q, addr_en_d;
  logic [1:0]         cmd_type_q, cmd_type_d;
  logic [1:0]         addr_type_q, addr_type_d;
  logic [1:0]         dat_type_q, dat_type_d;
  logic [1:0]         addr_idx_q, addr_idx_d;
  logic [3:0]         dummy_cnt_q, dummy_cnt_d;
  logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
  logic               done_q, done_d;

  logic               spi_vld, spi_hs, phase_end, last_byte;
  state_e             phase_nxt, post_addr, post_dummy;
  logic [31:0]        addr_ext;
  logic [7:0]         addr_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      addr_en_q   <= 1'b0;
      cmd_type_q  <= '0;
      addr_type_q <= '0;
      dat_type_q  <= '0;
      addr_idx_q  <= '0;
      dummy_cnt_q <= '0;
      len_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      addr_en_q   <= addr_en_d;
      cmd_type_q  <= cmd_type_d;
      addr_type_q <= addr_type_d;
      dat_type_q  <= dat_type_d;
      addr_idx_q  <= addr_idx_d;
      dummy_cnt_q <= dummy_cnt_d;
      len_cnt_q   <= len_cnt_d;
      done_q      <= done_d;
    end
  end

  assign spi_vld = (state_q == ST_DATA) ? wr_vld : (state_q != ST_IDLE);
  assign spi_hs  = spi_vld & i_spi_rdy;

  // The dummy and length counters double as the latched fields until their own phase starts.
  always_comb begin
    post_dummy = (len_cnt_q != '0) ? ST_DATA : ST_IDLE;
    post_addr  = (dummy_cnt_q != '0) ? ST_DUMMY : post_dummy;
    phase_end  = 1'b0;
    phase_nxt  = ST_IDLE;
    unique case (state_q)
      ST_CMD: begin
        phase_end = 1'b1;
        phase_nxt = addr_en_q ? ST_ADDR : post_addr;
      end
      ST_ADDR: begin
        phase_end = (addr_idx_q == 2'd3);
        phase_nxt = post_addr;
      end
      ST_DUMMY: begin
        phase_end = (dummy_cnt_q == 4'd1);
        phase_nxt = post_dummy;
      end
      ST_DATA: begin
        phase_end = (len_cnt_q == LEN_W'(1));
        phase_nxt = ST_IDLE;
      end
      default: ;
    endcase
    last_byte = phase_end & (phase_nxt == ST_IDLE);

    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    addr_en_d   = addr_en_q;
    cmd_type_d  = cmd_type_q;
    addr_type_d = addr_type_q;
    dat_type_d  = dat_type_q;
    addr_idx_d  = addr_idx_q;
    dummy_cnt_d = dummy_cnt_q;
    len_cnt_d   = len_cnt_q;
    done_d      = 1'b0;

    if (state_q == ST_IDLE) begin
      if (req_vld) begin
        state_d     = ST_CMD;
        cmd_d       = req_cmd;
        addr_d      = req_addr[ADDR_W-1:0];
        addr_en_d   = req_addr_en;
        cmd_type_d  = req_cmd_type;
        addr_type_d = req_addr_type;
        dat_type_d  = req_dat_type;
        addr_idx_d  = req_is_4b ? 2'd0 : 2'd1;
        dummy_cnt_d = req_dummy;
        len_cnt_d   = req_len;
      end
    end else if (spi_hs) begin
      unique case (state_q)
        ST_ADDR:  addr_idx_d  = addr_idx_q + 2'd1;
        ST_DUMMY: dummy_cnt_d = dummy_cnt_q - 4'd1;
        ST_DATA:  len_cnt_d   = len_cnt_q - LEN_W'(1);
        default: ;
      endcase
      if (phase_end) state_d = phase_nxt;
      done_d = last_byte;
    end
  end

  assign addr_ext = 32'(addr_q);

  always_comb begin
    unique case (addr_idx_q)
      2'd0:    addr_byte = addr_ext[31:24];
      2'd1:    addr_byte = addr_ext[23:16];
      2'd2:    addr_byte = addr_ext[15:8];
      default: addr_byte = addr_ext[7:0];
    endcase

    req_rdy        = 1'b0;
    wr_rdy         = 1'b0;
    o_spi_vld      = 1'b0;
    o_spi_dat      = '0;
    o_spi_type     = '0;
    o_spi_continue = 1'b0;
    if (rst_n) begin
      req_rdy        = (state_q == ST_IDLE);
      o_spi_vld      = spi_vld;
      o_spi_continue = (state_q != ST_IDLE) & ~last_byte;
      unique case (state_q)
        ST_CMD: begin
          o_spi_dat  = cmd_q;
          o_spi_type = lane_fix(cmd_type_q);
        end
        ST_ADDR: begin
          o_spi_dat  = addr_byte;
          o_spi_type = lane_fix(addr_type_q);
        end
        ST_DUMMY: begin
          o_spi_dat  = DUMMY_BYTE;
          o_spi_type = lane_fix(addr_type_q);
        end
        ST_DATA: begin
          o_spi_dat  = wr_dat;
          o_spi_type = lane_fix(dat_type_q);
          wr_rdy     = i_spi_rdy;
        end
        default: ;
      endcase
    end
  end

  assign busy = rst_n & (state_q != ST_IDLE);
  assign done = rst_n & done_q;

endmodule
